// File: rtl/breath_pkg.sv
// breath_pkg: mode and colour encodings shared by the breathing-LED engine
package breath_pkg;
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BREATH = 2'd1;
  localparam logic [1:0] MODE_CYCLE  = 2'd2;
  localparam logic [1:0] MODE_STATIC = 2'd3;
  localparam logic [1:0] COL_R = 2'd0;
  localparam logic [1:0] COL_G = 2'd1;
  localparam logic [1:0] COL_B = 2'd2;
endpackage

// File: rtl/breath_channel.sv
// breath_channel: one RGB channel's PWM frame counter, duty ramp, colour index and registered pins
module breath_channel
  import breath_pkg::*;
#(
  parameter int FREQ_W     = 4,
  parameter int BASE       = 1000,
  parameter int PWM_W      = 14,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq,
  input  logic [1:0]        mode,
  input  logic [1:0]        mode_nxt,
  output logic [2:0]        rgb,
  output logic              dark_pulse
);
  logic [PWM_W-1:0] f, d, pl, p_new, d_clamp;
  logic [1:0] c;
  logic up, wrap, hold, dark;
  logic [2:0] lit;
  always_comb begin
    p_new   = PWM_W'(BASE) * (freq == '0 ? PWM_W'(1) : PWM_W'(freq));
    d_clamp = d > p_new ? p_new : d;
    wrap    = f == pl - 1'b1;
    // hold covers both sitting in OFF and the edge that enters it, so a coincident wrap is dropped
    hold    = mode == MODE_OFF || mode_nxt == MODE_OFF;
    dark    = !up && d_clamp == '0;
    lit     = mode == MODE_OFF ? 3'b000 :
              (mode == MODE_STATIC || f < d) ? 3'b001 << c : 3'b000;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f          <= '0;
      d          <= '0;
      up         <= 1'b1;
      c          <= COL_R;
      pl         <= PWM_W'(BASE);
      rgb        <= {3{ACTIVE_LOW}};
      dark_pulse <= 1'b0;
    end else begin
      rgb        <= lit ^ {3{ACTIVE_LOW}};
      dark_pulse <= 1'b0;
      if (hold) begin
        f  <= '0;
        d  <= '0;
        up <= 1'b1;
        pl <= p_new;
      end else if (!wrap) begin
        f <= f + 1'b1;
      end else begin
        f          <= '0;
        pl         <= p_new;
        d          <= up ? (d_clamp == p_new ? d_clamp : d_clamp + 1'b1) :
                           (d_clamp == '0 ? d_clamp : d_clamp - 1'b1);
        up         <= up ? d_clamp != p_new : d_clamp == '0;
        dark_pulse <= dark;
        if (dark && mode == MODE_CYCLE) c <= c == COL_B ? COL_R : c + 2'd1;
      end
    end
  end
endmodule

// File: rtl/breath_led_array.sv
// breath_led_array: global mode register driving CH independent breathing RGB channels
module breath_led_array
  import breath_pkg::*;
#(
  parameter int CH         = 2,
  parameter int FREQ_W     = 4,
  parameter int BASE       = 1000,
  parameter int PWM_W      = 14,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*FREQ_W-1:0] freq,
  input  logic                 mode_step,
  output logic [3*CH-1:0]      rgb,
  output logic [1:0]           mode,
  output logic [CH-1:0]        dark_pulse
);
  logic [1:0] mode_nxt;
  always_comb mode_nxt = mode_step ? mode + 2'd1 : mode;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode <= MODE_BREATH;
    else mode <= mode_nxt;
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    breath_channel #(
      .FREQ_W(FREQ_W), .BASE(BASE), .PWM_W(PWM_W), .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .freq(freq[i*FREQ_W +: FREQ_W]),
      .mode(mode),
      .mode_nxt(mode_nxt),
      .rgb(rgb[3*i +: 3]),
      .dark_pulse(dark_pulse[i])
    );
  end
endmodule

// File: tb/tb_breath_led_array.sv
// tb_breath_led_array: randomized and directed checks against a per-channel behavioural model
module tb_breath_led_array;
  localparam int CH = 2, FREQ_W = 4, BASE = 4, PWM_W = 14;
  logic clk = 1'b0, rst = 1'b0, mode_step = 1'b0;
  logic [CH*FREQ_W-1:0] freq = '0;
  logic [3*CH-1:0] rgb;
  logic [1:0] mode;
  logic [CH-1:0] dark_pulse;
  int n_tests = 0, n_fail = 0, cyc = 0, first_dp0 = -1;
  int prev_dp[CH], last_dp[CH];
  int mm, mf[CH], md[CH], mpl[CH], mc[CH];
  bit mup[CH];
  logic [3*CH-1:0] e_rgb;
  logic [CH-1:0] e_dp;

  breath_led_array #(.CH(CH), .FREQ_W(FREQ_W), .BASE(BASE), .PWM_W(PWM_W), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .freq(freq), .mode_step(mode_step),
    .rgb(rgb), .mode(mode), .dark_pulse(dark_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mm = 1;
    for (int k = 0; k < CH; k++) begin
      mf[k] = 0; md[k] = 0; mup[k] = 1; mc[k] = 0; mpl[k] = BASE;
      prev_dp[k] = -1; last_dp[k] = -1;
    end
    e_rgb = '1;
    e_dp = '0;
  endtask

  // Registered pins reflect the state held before the edge; state then advances by the frame rules.
  task automatic model_step();
    int nm;
    nm = mode_step ? (mm + 1) % 4 : mm;
    for (int k = 0; k < CH; k++) begin
      int fq, p, lit;
      fq = int'(freq[k*FREQ_W +: FREQ_W]);
      p = BASE * (fq == 0 ? 1 : fq);
      lit = (mm == 0) ? 0 : (mm == 3 || mf[k] < md[k]) ? (1 << mc[k]) : 0;
      e_rgb[3*k +: 3] = 3'(lit) ^ 3'b111;
      e_dp[k] = 1'b0;
      if (mm == 0 || nm == 0) begin
        mf[k] = 0; md[k] = 0; mup[k] = 1; mpl[k] = p;
      end else if (mf[k] == mpl[k] - 1) begin
        mf[k] = 0;
        mpl[k] = p;
        if (md[k] > p) md[k] = p;
        if (mup[k]) begin
          if (md[k] == p) mup[k] = 0;
          else md[k]++;
        end else if (md[k] == 0) begin
          mup[k] = 1;
          e_dp[k] = 1'b1;
          if (mm == 2) mc[k] = (mc[k] + 1) % 3;
        end else md[k]--;
      end else mf[k]++;
    end
    mm = nm;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("rgb", 32'(rgb), 32'(e_rgb));
    check("mode", 32'(mode), 32'(mm));
    check("dark_pulse", 32'(dark_pulse), 32'(e_dp));
    for (int k = 0; k < CH; k++)
      if (dark_pulse[k]) begin
        prev_dp[k] = last_dp[k];
        last_dp[k] = cyc;
        if (k == 0 && first_dp0 < 0) first_dp0 = cyc;
      end
  endtask

  task automatic pulse_step();
    mode_step = 1'b1;
    tick();
    mode_step = 1'b0;
  endtask

  initial begin
    freq = {4'd1, 4'd1};
    model_reset();
    #12;
    check("reset_rgb", 32'(rgb), 32'h3f);
    check("reset_mode", 32'(mode), 32'd1);
    check("reset_dp", 32'(dark_pulse), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("early_dark", 32'(rgb), 32'h3f);
    end
    for (int i = 0; i < 40; i++) tick();
    check("first_dp0_cycle", 32'(first_dp0), 32'd40);
    freq = {4'd2, 4'd1};
    for (int i = 0; i < 600; i++) tick();
    check("ch0_period", 32'(last_dp[0] - prev_dp[0]), 32'd40);
    check("ch1_period", 32'(last_dp[1] - prev_dp[1]), 32'd144);
    pulse_step();
    check("mode_cycle", 32'(mode), 32'd2);
    for (int i = 0; i < 500; i++) tick();
    pulse_step();
    check("mode_static", 32'(mode), 32'd3);
    tick();
    check("static_one_lit", 32'($countones(rgb[2:0])), 32'd2);
    for (int i = 0; i < 20; i++) tick();
    pulse_step();
    check("mode_off", 32'(mode), 32'd0);
    tick();
    check("off_dark", 32'(rgb), 32'h3f);
    for (int i = 0; i < 10; i++) tick();
    pulse_step();
    check("mode_breath", 32'(mode), 32'd1);
    freq = {4'd1, 4'd3};
    for (int g = 0; g < 3000 && !(md[0] == 10 && mf[0] < mpl[0] - 2); g++) tick();
    freq = {4'd1, 4'd1};
    for (int i = 0; i < 100; i++) tick();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) freq = CH*FREQ_W'($urandom);
      mode_step = $urandom_range(0, 199) == 0;
      tick();
    end
    mode_step = 1'b0;
    freq = {4'd1, 4'd1};
    for (int g = 0; g < 8 && mm != 3; g++) pulse_step();
    for (int g = 0; g < 2000 && !(mup[0] == 0 && md[0] == 0 && mf[0] == mpl[0] - 1); g++) tick();
    pulse_step();
    check("coinc_no_dp", 32'(dark_pulse[0]), 32'd0);
    check("coinc_mode_off", 32'(mode), 32'd0);
    tick();
    check("coinc_dark", 32'(rgb), 32'h3f);
    pulse_step();
    for (int g = 0; g < 200 && !(md[0] == 3 && mup[0] && mf[0] == 0); g++) tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rgb", 32'(rgb), 32'h3f);
    check("async_mode", 32'(mode), 32'd1);
    check("async_dp", 32'(dark_pulse), 32'd0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
